// File: rtl/reg_access_master.sv
// reg_access_master: decodes byte-stream write/read frames into register-file
// strobes and returns read words as two bytes (low, high) over valid/ready.
module reg_access_master #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [7:0]            CMD_WR       = 8'hAA;
    localparam logic [7:0]            CMD_RD       = 8'hBB;
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_WORD = DATA_WIDTH'(16'hEEEE);
    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, W_ADDR, W_LO, W_HI, W_EXEC, R_ADDR, R_EXEC, R_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                state_q,    state_d;
    logic                  wr_en_q,    wr_en_d;
    logic                  rd_en_q,    rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0] frm_addr_q, frm_addr_d;
    logic [7:0]            frm_lo_q,   frm_lo_d;
    logic [DATA_WIDTH-1:0] rd_word_q,  rd_word_d;

    // Next-state and next-output logic; strobes default low, everything else holds.
    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cnt_d      = cnt_q;
        frm_addr_d = frm_addr_q;
        frm_lo_d   = frm_lo_q;
        rd_word_d  = rd_word_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR) begin
                        state_d = W_ADDR;
                    end else if (rx_data == CMD_RD) begin
                        state_d = R_ADDR;
                    end
                end
            end
            W_ADDR: begin
                if (rx_valid) begin
                    frm_addr_d = rx_data[ADDR_WIDTH-1:0];
                    state_d    = W_LO;
                end
            end
            W_LO: begin
                if (rx_valid) begin
                    frm_lo_d = rx_data;
                    state_d  = W_HI;
                end
            end
            W_HI: begin
                // Address/WrData change only when the strobe fires, so they
                // hold across aborted frames.
                if (rx_valid) begin
                    addr_d  = frm_addr_q;
                    wdata_d = {rx_data, frm_lo_q};
                    wr_en_d = 1'b1;
                    state_d = W_EXEC;
                end
            end
            W_EXEC: begin
                state_d = IDLE;
            end
            R_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = R_EXEC;
                end
            end
            R_EXEC: begin
                cnt_d   = '0;
                state_d = R_WAIT;
            end
            R_WAIT: begin
                // Valid data wins over a timeout expiring in the same cycle.
                if (RdData_Valid) begin
                    rd_word_d  = RdData;
                    tx_data_d  = RdData[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = TX_LO;
                end else if (cnt_q == CNT_LAST) begin
                    rd_word_d  = TIMEOUT_WORD;
                    tx_data_d  = TIMEOUT_WORD[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = TX_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_LO: begin
                if (tx_valid_q && tx_ready) begin
                    tx_data_d = rd_word_q[DATA_WIDTH-1:8];
                    state_d   = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cnt_q      <= '0;
            frm_addr_q <= '0;
            frm_lo_q   <= '0;
            rd_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cnt_q      <= cnt_d;
            frm_addr_q <= frm_addr_d;
            frm_lo_q   <= frm_lo_d;
            rd_word_q  <= rd_word_d;
        end
    end

    assign WrEn     = wr_en_q;
    assign RdEn     = rd_en_q;
    assign Address  = addr_q;
    assign WrData   = wdata_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_master.sv
// Testbench for reg_access_master: directed frames, register-file model,
// scoreboard of expected strobes/tx bytes checked by an independent monitor.
module tb_reg_access_master;

    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_TX = 2;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        RdData_Valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    logic [15:0] mem [8];
    logic        rf_dead;
    logic        rd_pend;
    logic [15:0] rd_pend_data;

    reg_access_master #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(16),
        .RD_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .RdData      (RdData),
        .RdData_Valid(RdData_Valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Register-file model: writes on WrEn, answers a read one cycle after RdEn.
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        RdData       = 16'h0000;
        RdData_Valid = 1'b0;
        rd_pend      = 1'b0;
        rd_pend_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            RdData_Valid = rd_pend;
            RdData       = rd_pend_data;
            rd_pend      = RdEn && !rf_dead && !RST;
            rd_pend_data = mem[Address];
            if (WrEn && !RST) mem[Address] = WrData;
        end
    end

    task automatic mon_event(input int kind, input logic [7:0] addr, input logic [15:0] data);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", kind, addr, data);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                errors++;
                $display("FAIL sb_event: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: mid-cycle sampling of strobes and tx handshakes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!RST) begin
                check("wr_rd_exclusive", 16'(WrEn && RdEn), 16'h0);
                if (WrEn)                 mon_event(EV_WR, 8'(Address), WrData);
                if (RdEn)                 mon_event(EV_RD, 8'(Address), 16'h0000);
                if (tx_valid && tx_ready) mon_event(EV_TX, 8'h00, 16'(tx_data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cyc();
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc();
            if (!busy && sb_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d, expected idle with 0 pending",
                     name, busy, sb_q.size());
        end
    endtask

    initial begin
        bit seen;
        RST      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        rf_dead  = 1'b0;
        cyc();
        cyc();
        check("rst_wren",     16'(WrEn),     16'h0);
        check("rst_rden",     16'(RdEn),     16'h0);
        check("rst_txvalid",  16'(tx_valid), 16'h0);
        check("rst_busy",     16'(busy),     16'h0);
        check("rst_address",  16'(Address),  16'h0);
        check("rst_wrdata",   WrData,        16'h0);
        check("rst_txdata",   16'(tx_data),  16'h0);
        RST = 1'b0;

        // Write then read back
        push_exp(EV_WR, 8'h05, 16'h1234);
        send_byte(8'hAA);
        check("w_busy", 16'(busy), 16'h1);
        send_byte(8'h05);
        send_byte(8'h34);
        send_byte(8'h12);
        check("wr_latency", 16'(WrEn), 16'h1);
        wait_idle("write1");
        push_exp(EV_RD, 8'h05, 16'h0000);
        push_exp(EV_TX, 8'h00, 16'h0034);
        push_exp(EV_TX, 8'h00, 16'h0012);
        send_byte(8'hBB);
        send_byte(8'h05);
        check("rd_latency", 16'(RdEn), 16'h1);
        cyc();
        check("tx_not_yet", 16'(tx_valid), 16'h0);
        cyc();
        check("rd_to_tx_latency", 16'(tx_valid), 16'h1);
        wait_idle("read1");

        // Address truncation
        push_exp(EV_WR, 8'h04, 16'h0007);
        send_byte(8'hAA);
        send_byte(8'hFC);
        send_byte(8'h07);
        send_byte(8'h00);
        wait_idle("write_trunc");
        push_exp(EV_RD, 8'h04, 16'h0000);
        push_exp(EV_TX, 8'h00, 16'h0007);
        push_exp(EV_TX, 8'h00, 16'h0000);
        send_byte(8'hBB);
        send_byte(8'h04);
        wait_idle("read_trunc");

        // Unknown command: nothing expected on the scoreboard
        send_byte(8'h55);
        check("unk_busy0", 16'(busy), 16'h0);
        send_byte(8'h05);
        check("unk_busy1", 16'(busy), 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("unk_idle", 16'({busy, tx_valid}), 16'h0);
        end

        // Read timeout: register file never answers
        rf_dead = 1'b1;
        push_exp(EV_RD, 8'h02, 16'h0000);
        push_exp(EV_TX, 8'h00, 16'h00EE);
        push_exp(EV_TX, 8'h00, 16'h00EE);
        send_byte(8'hBB);
        send_byte(8'h02);
        check("to_rden", 16'(RdEn), 16'h1);
        for (int i = 0; i < 4; i++) cyc();
        check("to_still_waiting", 16'(tx_valid), 16'h0);
        cyc();
        check("to_tx_valid", 16'(tx_valid), 16'h1);
        check("to_tx_lo", 16'(tx_data), 16'h00EE);
        wait_idle("read_timeout");
        rf_dead = 1'b0;

        // Backpressure on a read of 0xABCD, with stray rx bytes during transmit
        push_exp(EV_WR, 8'h06, 16'hABCD);
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'hCD);
        send_byte(8'hAB);
        wait_idle("write_abcd");
        tx_ready = 1'b0;
        push_exp(EV_RD, 8'h06, 16'h0000);
        push_exp(EV_TX, 8'h00, 16'h00CD);
        push_exp(EV_TX, 8'h00, 16'h00AB);
        send_byte(8'hBB);
        send_byte(8'h06);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (tx_valid) seen = 1'b1;
        end
        check("bp_tx_valid_rise", 16'(seen), 16'h1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            rx_valid = (i == 2 || i == 5);
            rx_data  = (i == 2) ? 8'hAA : 8'hBB;
            check("bp_hold", {7'h0, tx_valid, tx_data}, 16'h01CD);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_idle("read_bp");

        // Reset in the middle of a write frame
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check("mid_rst_busy", 16'(busy), 16'h0);
        check("mid_rst_wren", 16'(WrEn), 16'h0);
        send_byte(8'h22);
        check("after_rst_busy", 16'(busy), 16'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("after_rst_nostrobe", 16'({WrEn, RdEn}), 16'h0);
        end

        check("sb_empty", 16'(sb_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_access_master.md
# reg_access_master

Command-driven master for the 8x16 register file. It takes a byte stream from the serial receive path, decodes write and read command frames, and drives single-cycle write and read strobes into the register file. It captures each read result and returns it as bytes, low then high, on a valid/ready output port toward the serial transmit path. It sits between the UART RX/TX pair and the register file, in the same clock domain as the register file.

## Interface
- ADDR_WIDTH, 3, register-file address width (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 16, register-file word width; fixed at 16 (two bytes per word)
- RD_TIMEOUT, 4, cycles to wait for RdData_Valid after RdEn before aborting

Ports:
- clk  in  1  system clock, rising-edge
- RST  in  1  reset, synchronous, active-high
- rx_data  in  8  incoming frame byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  RdData is valid this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmit path accepts tx_data this cycle
- busy  out  1  high in every state except IDLE

## Operation
- Frames:
  - write: 0xAA, addr, data_lo, data_hi
  - read: 0xBB, addr
  - any other first byte is discarded; the block stays in IDLE.
- Address bytes are truncated to bits [ADDR_WIDTH-1:0]; upper bits are ignored.
- FSM states: IDLE, W_ADDR, W_LO, W_HI, W_EXEC, R_ADDR, R_EXEC, R_WAIT, TX_LO, TX_HI.
- Transitions:
  - IDLE: 0xAA goes to W_ADDR; 0xBB goes to R_ADDR.
  - W_ADDR, W_LO, W_HI each advance on rx_valid, latching addr, data_lo and data_hi in turn.
  - W_EXEC asserts WrEn for 1 cycle, then returns to IDLE.
  - R_ADDR goes to R_EXEC on rx_valid.
  - R_EXEC asserts RdEn for 1 cycle, then goes to R_WAIT.
  - R_WAIT latches RdData on RdData_Valid and goes to TX_LO.
  - If RD_TIMEOUT cycles pass in R_WAIT without RdData_Valid, the latched word is forced to 0xEEEE and the FSM goes to TX_LO.
  - TX_LO presents the low byte; TX_HI presents the high byte. Each advances on tx_valid && tx_ready. TX_HI returns to IDLE.
- No write response is sent.
- rx_valid is ignored in W_EXEC, R_EXEC, R_WAIT, TX_LO and TX_HI; those bytes are dropped.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last driven values between transactions.

## Timing
- Reset values, taking effect on the first rising clk edge with RST=1:
  - state = IDLE
  - WrEn = 0, RdEn = 0, tx_valid = 0, busy = 0
  - Address = 0, WrData = 0, tx_data = 0
  - timeout counter = 0
- Reset mid-frame or mid-transmit aborts the transaction at that edge. No strobe is issued afterwards. Any pending tx byte is dropped.
- All outputs are registered.
- Write latency: WrEn is high in the cycle after the clk edge that samples the data_hi rx_valid. Address and WrData are stable in that cycle.
- Read latency: RdEn is high in the cycle after the clk edge that samples the addr rx_valid.
- The register file normally asserts RdData_Valid in the cycle after RdEn. In that case tx_valid rises 2 cycles after RdEn.
- RdData_Valid arriving on the same cycle the timeout expires is accepted as real data.
- Timeout counter:
  - counts cycles in R_WAIT starting from 0
  - the abort occurs on the edge where the count reaches RD_TIMEOUT-1 with no valid
- tx handshake:
  - tx_valid stays high and tx_data stays stable until tx_ready is sampled high.
  - After the low-byte handshake, the high byte appears the next cycle.
  - After the high-byte handshake, tx_valid is low the next cycle.
- busy is combinational from state and is high from the edge that leaves IDLE.

## Test plan
- Write then read: send AA,05,34,12; then BB,05. Required: WrEn pulses once with Address=5, WrData=0x1234; RdEn pulses with Address=5; tx bytes 0x34 then 0x12.
- Address truncation: send AA,FC,07,00, then read with BB,04. Required: the write hits Address=4; readback is 0x07, 0x00.
- Unknown command: send 0x55,0x05. Required: no WrEn, no RdEn, no tx_valid; busy=0 throughout.
- Read timeout: send BB,02 with RdData_Valid tied low. Required: after 4 wait cycles, tx bytes are 0xEE, 0xEE.
- tx backpressure: hold tx_ready=0 for 10 cycles during a read of 0xABCD. Required: tx_valid=1 with tx_data=0xCD stable throughout; then 0xCD, 0xAB after ready. rx bytes arriving meanwhile cause no strobes.
- Reset mid-write: after AA,03,11, assert RST for 1 cycle, then send 0x22. Required: no WrEn; state is IDLE and busy=0 after the reset edge.
